// File: rtl/mmio_responder.sv
// Memory-mapped responder: TX byte FIFO, cycle counter, STATUS/CTRL and a level irq.
// Optional compare register and cmp_hit interrupt are enabled by defining MMIO_CYCLE_CMP_EN.
module mmio_responder #(
  parameter logic [63:0] BASE_ADDR  = 64'h0000_0000_0000_0100,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] raddress,
  input  logic [63:0] waddress,
  input  logic [63:0] Datain,
  input  logic        Wr,
  output logic [63:0] Dataout,
  output logic        hit,
  output logic        out_valid,
  output logic [7:0]  out_data,
  input  logic        out_ready,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
`ifdef MMIO_CYCLE_CMP_EN
  localparam logic [63:0] WIN_SIZE = 64'h28;
`else
  localparam logic [63:0] WIN_SIZE = 64'h20;
`endif

  localparam logic [2:0] IDX_TXDATA = 3'd0;
  localparam logic [2:0] IDX_STATUS = 3'd1;
  localparam logic [2:0] IDX_CYCLE  = 3'd2;
  localparam logic [2:0] IDX_CTRL   = 3'd3;
  localparam logic [2:0] IDX_CMP    = 3'd4;

  logic [7:0]    fifoMem [FIFO_DEPTH];
  logic [AW-1:0] wrPtr, rdPtr;
  logic [CW-1:0] count;
  logic          overflow;
  logic [63:0]   cycleCnt;
  logic          irqEn;
`ifdef MMIO_CYCLE_CMP_EN
  logic [63:0]   cmpReg;
  logic          cmpHit;
  logic          cmpIrqEn;
`endif

  logic [63:0] rOff, wOff;
  logic        wHit;
  logic        txWr, cycWr, ctrlWr;
  logic        empty, full, push, pop;
  logic [63:0] statusVal, rdVal;

  // Subtraction wraps for addresses below the base, so they fail the range test.
  assign rOff = raddress - BASE_ADDR;
  assign wOff = waddress - BASE_ADDR;
  assign hit  = (rOff < WIN_SIZE) && (rOff[2:0] == 3'b000);
  assign wHit = Wr && (wOff < WIN_SIZE) && (wOff[2:0] == 3'b000);

  assign txWr   = wHit && (wOff[5:3] == IDX_TXDATA);
  assign cycWr  = wHit && (wOff[5:3] == IDX_CYCLE);
  assign ctrlWr = wHit && (wOff[5:3] == IDX_CTRL);

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));
  assign pop   = !empty && out_ready;
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign push  = txWr && (!full || pop);

  assign out_valid = !empty;
  assign out_data  = fifoMem[rdPtr];

  always_comb begin
    statusVal         = '0;
    statusVal[0]      = empty;
    statusVal[1]      = full;
    statusVal[8 +: CW] = count;
    statusVal[16]     = overflow;
`ifdef MMIO_CYCLE_CMP_EN
    statusVal[17]     = cmpHit;
`endif
  end

  always_comb begin
    rdVal = '0;
    if (hit) begin
      case (rOff[5:3])
        IDX_STATUS: rdVal = statusVal;
        IDX_CYCLE:  rdVal = cycleCnt;
        IDX_CTRL: begin
          rdVal[0] = irqEn;
`ifdef MMIO_CYCLE_CMP_EN
          rdVal[1] = cmpIrqEn;
`endif
        end
`ifdef MMIO_CYCLE_CMP_EN
        IDX_CMP:    rdVal = cmpReg;
`endif
        default:    rdVal = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifoMem[wrPtr] <= Datain[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      Dataout  <= '0;
      wrPtr    <= '0;
      rdPtr    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      cycleCnt <= '0;
      irqEn    <= 1'b0;
      irq      <= 1'b0;
`ifdef MMIO_CYCLE_CMP_EN
      cmpReg   <= '1;
      cmpHit   <= 1'b0;
      cmpIrqEn <= 1'b0;
`endif
    end else begin
      Dataout <= rdVal;

      if (push) wrPtr <= wrPtr + AW'(1);
      if (pop)  rdPtr <= rdPtr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);

      if (txWr && full && !pop)         overflow <= 1'b1;
      else if (ctrlWr && Datain[8])     overflow <= 1'b0;

      cycleCnt <= cycWr ? Datain : cycleCnt + 64'd1;

      if (ctrlWr) irqEn <= Datain[0];

`ifdef MMIO_CYCLE_CMP_EN
      if (wHit && (wOff[5:3] == IDX_CMP)) cmpReg <= Datain;
      if (ctrlWr) cmpIrqEn <= Datain[1];
      if (cycleCnt == cmpReg)          cmpHit <= 1'b1;
      else if (ctrlWr && Datain[9])    cmpHit <= 1'b0;
      irq <= (irqEn & empty) | (cmpIrqEn & cmpHit);
`else
      irq <= irqEn & empty;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder (default build, FIFO_DEPTH=8, base 0x100).
module tb_mmio_responder;

  localparam logic [63:0] BASE = 64'h0000_0000_0000_0100;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] raddress, waddress, Datain;
  logic        Wr;
  logic [63:0] Dataout;
  logic        hit;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        irq;

  int nChecks = 0;
  int nPass   = 0;

  mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(8)) dut (
    .clk(clk), .reset(reset), .raddress(raddress), .waddress(waddress),
    .Datain(Datain), .Wr(Wr), .Dataout(Dataout), .hit(hit),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wrReg(input logic [63:0] addr, input logic [63:0] data);
    waddress = addr;
    Datain   = data;
    Wr       = 1'b1;
    step();
    Wr       = 1'b0;
  endtask

  initial begin
    logic [7:0] drainExp [8];
    reset = 1'b1; Wr = 1'b0; out_ready = 1'b0;
    raddress = BASE + 64'h08; waddress = '0; Datain = '0;
    step(); step();
    check("reset_dataout", Dataout, 64'h0);
    check("reset_valid", {63'b0, out_valid}, 64'h0);
    check("reset_irq", {63'b0, irq}, 64'h0);
    reset = 1'b0;
    check("hit_status", {63'b0, hit}, 64'h1);
    step();
    check("status_empty", Dataout, 64'h1);

    // three bytes, then drain
    wrReg(BASE, 64'h41);
    wrReg(BASE, 64'h42);
    wrReg(BASE, 64'h43);
    step();
    check("status_cnt3", Dataout, 64'h300);
    check("head_41", {56'b0, out_data}, 64'h41);
    out_ready = 1'b1;
    step();
    check("head_42", {56'b0, out_data}, 64'h42);
    step();
    check("head_43", {56'b0, out_data}, 64'h43);
    step();
    check("drained_valid", {63'b0, out_valid}, 64'h0);
    out_ready = 1'b0;

    // overflow: 9 bytes into depth 8
    for (int i = 0; i < 9; i++) wrReg(BASE, 64'h50 + 64'(i));
    step();
    check("status_ovf", Dataout, 64'h0001_0802);
    wrReg(BASE + 64'h18, 64'h100);
    step();
    check("status_ovf_clr", Dataout, 64'h802);

    // push and pop together while full
    out_ready = 1'b1;
    wrReg(BASE, 64'h77);
    out_ready = 1'b0;
    step();
    check("status_full_pp", Dataout, 64'h802);
    for (int i = 0; i < 7; i++) drainExp[i] = 8'h51 + 8'(i);
    drainExp[7] = 8'h77;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_%0d", i), {56'b0, out_data}, {56'b0, drainExp[i]});
      step();
    end
    check("drain_done", {63'b0, out_valid}, 64'h0);
    out_ready = 1'b0;

    // cycle counter wrap
    raddress = BASE + 64'h10;
    wrReg(BASE + 64'h10, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check("cyc_fe", Dataout, 64'hFFFF_FFFF_FFFF_FFFE);
    step();
    check("cyc_ff", Dataout, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    check("cyc_wrap", Dataout, 64'h0);
    wrReg(BASE + 64'h10, 64'h1234);
    check("cyc_old_on_write", Dataout, 64'h1);
    step();
    check("cyc_loaded", Dataout, 64'h1234);

    // misses
    raddress = BASE + 64'h04;
    #1 check("hit_unaligned", {63'b0, hit}, 64'h0);
    step();
    check("rd_unaligned", Dataout, 64'h0);
    raddress = BASE + 64'h40;
    #1 check("hit_range", {63'b0, hit}, 64'h0);
    step();
    check("rd_range", Dataout, 64'h0);
    raddress = BASE + 64'h20;
    #1 check("hit_cmp_absent", {63'b0, hit}, 64'h0);
    raddress = BASE - 64'h08;
    #1 check("hit_below", {63'b0, hit}, 64'h0);
    wrReg(BASE + 64'h1C, 64'h1);
    raddress = BASE + 64'h18;
    step();
    check("ctrl_unaligned_wr", Dataout, 64'h0);
    check("irq_still_low", {63'b0, irq}, 64'h0);

    // interrupt
    wrReg(BASE + 64'h18, 64'h101);
    check("irq_lag", {63'b0, irq}, 64'h0);
    step();
    check("irq_rise", {63'b0, irq}, 64'h1);
    check("ctrl_read", Dataout, 64'h1);
    wrReg(BASE, 64'h99);
    check("push_visible", {63'b0, out_valid}, 64'h1);
    check("irq_hold", {63'b0, irq}, 64'h1);
    step();
    check("irq_fall", {63'b0, irq}, 64'h0);

    // reset mid-operation
    wrReg(BASE, 64'h9A);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rst_valid", {63'b0, out_valid}, 64'h0);
    check("rst_irq", {63'b0, irq}, 64'h0);
    raddress = BASE + 64'h08;
    step();
    check("rst_status", Dataout, 64'h1);
    raddress = BASE + 64'h18;
    step();
    check("rst_ctrl", Dataout, 64'h0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
